// File: rtl/lc3_cpu_top.sv
`default_nettype none
// ============================================================================
//  Module   : lc3_cpu_top
//  Purpose  : Multi-cycle LC-3 CPU with internal 2**ADDR_W x 16 word RAM and
//             memory-mapped keyboard (KBSR/KBDR) and display (DSR/DDR)
//             registers. Runs from RESET_PC and halts on TRAP x25.
//  Ports    : clk          - single clock, posedge
//             rst          - synchronous active-high reset
//             pad_kbdr     - [7:0] key char, [15] key strobe
//             pad_in_dsr   - [15] external display ready
//             pad_kbsr     - {kb_ready, 15'b0}
//             pad_ddr      - last value written to xFE06
//             pad_out_dsr  - {dsr_ready, 14'b0, ddr_strobe}
//  Revision : 1.0  initial release
// ============================================================================
module lc3_cpu_top #(
    parameter int          ADDR_W    = 8,
    parameter logic [15:0] RESET_PC  = 16'h3000,
    parameter string       INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pad_kbdr,
    input  logic [15:0] pad_in_dsr,
    output logic [15:0] pad_kbsr,
    output logic [15:0] pad_ddr,
    output logic [15:0] pad_out_dsr
);
    localparam logic [15:0] c_addr_kbsr = 16'hFE00;
    localparam logic [15:0] c_addr_kbdr = 16'hFE02;
    localparam logic [15:0] c_addr_dsr  = 16'hFE04;
    localparam logic [15:0] c_addr_ddr  = 16'hFE06;

    localparam logic [3:0] c_op_br   = 4'b0000, c_op_add = 4'b0001, c_op_ld  = 4'b0010;
    localparam logic [3:0] c_op_st   = 4'b0011, c_op_jsr = 4'b0100, c_op_and = 4'b0101;
    localparam logic [3:0] c_op_ldr  = 4'b0110, c_op_str = 4'b0111, c_op_not = 4'b1001;
    localparam logic [3:0] c_op_ldi  = 4'b1010, c_op_sti = 4'b1011, c_op_jmp = 4'b1100;
    localparam logic [3:0] c_op_lea  = 4'b1110, c_op_trap = 4'b1111;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_IND, S_LOAD_WB, S_TRAP_WB, S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d, ir_q, ir_d, rdata_q, rdata_d;
    logic [2:0]  nzp_q, nzp_d;
    logic [15:0] regs_q [8];
    logic [15:0] regs_d [8];
    logic        kb_ready_q, kb_ready_d, kb_strobe_q;
    logic [15:0] kbdr_q, kbdr_d, ddr_q, ddr_d;
    logic        dsr_ready_q, dsr_ready_d, ddr_strobe_q, ddr_strobe_d;
    logic [15:0] ram_q [2**ADDR_W];

    // Memory request issued by the control FSM this cycle
    logic        mem_rd, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic [ADDR_W-1:0] ram_idx;
    logic        hit_kbsr, hit_kbdr, hit_dsr, hit_ddr, ram_we, ddr_we, kb_edge;

    // Instruction fields
    logic [3:0]  f_op;
    logic [2:0]  f_dr, f_sr1, f_sr2;
    logic [15:0] off6, off9, off11, alu_b, wb_val;
    logic        wb_en;
    logic        unused_pads;

    assign f_op   = ir_q[15:12];
    assign f_dr   = ir_q[11:9];
    assign f_sr1  = ir_q[8:6];
    assign f_sr2  = ir_q[2:0];
    assign off6   = {{10{ir_q[5]}}, ir_q[5:0]};
    assign off9   = {{7{ir_q[8]}}, ir_q[8:0]};
    assign off11  = {{5{ir_q[10]}}, ir_q[10:0]};
    assign alu_b  = ir_q[5] ? {{11{ir_q[4]}}, ir_q[4:0]} : regs_q[f_sr2];
    assign unused_pads = ^{pad_kbdr[14:8], pad_in_dsr[14:0]};

    function automatic logic [2:0] nzp_of(input logic [15:0] v);
        if (v[15])          return 3'b100;
        else if (v == '0)   return 3'b010;
        else                return 3'b001;
    endfunction

    // ---------------- control FSM: next state and datapath ----------------
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        nzp_d     = nzp_q;
        regs_d    = regs_q;
        mem_rd    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc_q;
        mem_wdata = regs_q[f_dr];
        wb_en     = 1'b0;
        wb_val    = rdata_q;
        case (state_q)
            S_FETCH: begin
                mem_rd  = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ir_d    = rdata_q;
                pc_d    = pc_q + 16'd1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (f_op)
                    c_op_add: begin wb_en = 1'b1; wb_val = regs_q[f_sr1] + alu_b; end
                    c_op_and: begin wb_en = 1'b1; wb_val = regs_q[f_sr1] & alu_b; end
                    c_op_not: begin wb_en = 1'b1; wb_val = ~regs_q[f_sr1]; end
                    c_op_lea: begin wb_en = 1'b1; wb_val = pc_q + off9; end
                    c_op_br:  if (|(f_dr & nzp_q)) pc_d = pc_q + off9;
                    c_op_jmp: pc_d = regs_q[f_sr1];
                    c_op_jsr: begin
                        // Target uses the old base register, so JSRR R7 works
                        pc_d      = ir_q[11] ? pc_q + off11 : regs_q[f_sr1];
                        regs_d[7] = pc_q;
                    end
                    c_op_ld:  begin mem_rd = 1'b1; mem_addr = pc_q + off9;          state_d = S_LOAD_WB; end
                    c_op_ldr: begin mem_rd = 1'b1; mem_addr = regs_q[f_sr1] + off6; state_d = S_LOAD_WB; end
                    c_op_ldi, c_op_sti: begin
                        mem_rd   = 1'b1;
                        mem_addr = pc_q + off9;
                        state_d  = S_IND;
                    end
                    c_op_st:  begin mem_we = 1'b1; mem_addr = pc_q + off9; end
                    c_op_str: begin mem_we = 1'b1; mem_addr = regs_q[f_sr1] + off6; end
                    c_op_trap: begin
                        regs_d[7] = pc_q;
                        if (ir_q[7:0] == 8'h25) begin
                            state_d = S_HALT;
                        end else begin
                            mem_rd   = 1'b1;
                            mem_addr = {8'h00, ir_q[7:0]};
                            state_d  = S_TRAP_WB;
                        end
                    end
                    default: ;  // RTI and reserved opcode behave as NOPs
                endcase
            end
            S_IND: begin
                mem_addr = rdata_q;
                if (f_op == c_op_ldi) begin
                    mem_rd  = 1'b1;
                    state_d = S_LOAD_WB;
                end else begin
                    mem_we  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_LOAD_WB: begin
                wb_en   = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP_WB: begin
                pc_d    = rdata_q;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
        if (wb_en) begin
            regs_d[f_dr] = wb_val;
            nzp_d        = nzp_of(wb_val);
        end
    end

    // ---------------- address decode, read mux and peripherals ----------------
    assign ram_idx  = mem_addr[ADDR_W-1:0];
    assign hit_kbsr = (mem_addr == c_addr_kbsr);
    assign hit_kbdr = (mem_addr == c_addr_kbdr);
    assign hit_dsr  = (mem_addr == c_addr_dsr);
    assign hit_ddr  = (mem_addr == c_addr_ddr);
    assign ram_we   = mem_we & ~(hit_kbsr | hit_kbdr | hit_dsr | hit_ddr);
    assign ddr_we   = mem_we & hit_ddr;
    assign kb_edge  = pad_kbdr[15] & ~kb_strobe_q;

    always_comb begin
        rdata_d = rdata_q;
        if (mem_rd) begin
            if (hit_kbsr)      rdata_d = {kb_ready_q, 15'b0};
            else if (hit_kbdr) rdata_d = kbdr_q;
            else if (hit_dsr)  rdata_d = {dsr_ready_q, 15'b0};
            else if (hit_ddr)  rdata_d = ddr_q;
            else               rdata_d = ram_q[ram_idx];
        end
        // A new key edge outranks a same-cycle KBDR read clear
        kb_ready_d = kb_ready_q;
        if (kb_edge)                  kb_ready_d = 1'b1;
        else if (mem_rd && hit_kbdr)  kb_ready_d = 1'b0;
        kbdr_d       = kb_edge ? {8'h00, pad_kbdr[7:0]} : kbdr_q;
        ddr_d        = ddr_we ? mem_wdata : ddr_q;
        ddr_strobe_d = ddr_we;
        dsr_ready_d  = ddr_we ? 1'b0 : pad_in_dsr[15];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            ir_q         <= '0;
            nzp_q        <= 3'b010;
            rdata_q      <= '0;
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
            kb_ready_q   <= 1'b0;
            kb_strobe_q  <= 1'b0;
            kbdr_q       <= '0;
            ddr_q        <= '0;
            dsr_ready_q  <= 1'b0;
            ddr_strobe_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            nzp_q        <= nzp_d;
            rdata_q      <= rdata_d;
            regs_q       <= regs_d;
            kb_ready_q   <= kb_ready_d;
            kb_strobe_q  <= pad_kbdr[15];
            kbdr_q       <= kbdr_d;
            ddr_q        <= ddr_d;
            dsr_ready_q  <= dsr_ready_d;
            ddr_strobe_q <= ddr_strobe_d;
        end
    end

    // RAM contents survive reset; stores are suppressed while reset is held
    always_ff @(posedge clk) begin
        if (ram_we && !rst) ram_q[ram_idx] <= mem_wdata;
    end

    assign pad_kbsr    = {kb_ready_q, 15'b0};
    assign pad_ddr     = ddr_q;
    assign pad_out_dsr = {dsr_ready_q, 14'b0, ddr_strobe_q};

endmodule
`default_nettype wire

// File: tb/tb_lc3_cpu_top.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lc3_cpu_top
//  Purpose  : Self-checking bench for lc3_cpu_top: directed I/O and control
//             flow scenarios plus random programs compared against an
//             instruction-level LC-3 interpreter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lc3_cpu_top;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pad_kbdr = '0;
    logic [15:0] pad_in_dsr = '0;
    logic [15:0] pad_kbsr, pad_ddr, pad_out_dsr;

    always #5 clk = ~clk;

    lc3_cpu_top dut (
        .clk         (clk),
        .rst         (rst),
        .pad_kbdr    (pad_kbdr),
        .pad_in_dsr  (pad_in_dsr),
        .pad_kbsr    (pad_kbsr),
        .pad_ddr     (pad_ddr),
        .pad_out_dsr (pad_out_dsr)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Program image, loaded into the DUT RAM while reset is held
    logic [15:0] img [256];

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = 16'h0000;
    endtask

    // Loads img, applies one reset edge, leaves rst high
    task automatic load_hold();
        rst = 1'b1;
        for (int i = 0; i < 256; i++) dut.ram_q[i] <= img[i];
        tick(1);
    endtask

    task automatic start();
        load_hold();
        rst = 1'b0;
    endtask

    // ---------------- instruction-level reference model ----------------
    logic [15:0] m_mem [256];
    logic [15:0] m_reg [8];
    logic [15:0] m_pc, m_ddr;
    logic [2:0]  m_nzp;
    bit          m_halt;

    function automatic logic [15:0] m_rd(input logic [15:0] a);
        case (a)
            16'hFE00, 16'hFE02, 16'hFE04: return 16'h0000; // no key, display not ready
            16'hFE06: return m_ddr;
            default:  return m_mem[a[7:0]];
        endcase
    endfunction

    function automatic void m_wr(input logic [15:0] a, input logic [15:0] v);
        if (a == 16'hFE06) m_ddr = v;
        else if (a != 16'hFE00 && a != 16'hFE02 && a != 16'hFE04) m_mem[a[7:0]] = v;
    endfunction

    function automatic void m_set(input logic [2:0] r, input logic [15:0] v);
        m_reg[r] = v;
        m_nzp = v[15] ? 3'b100 : (v == 16'h0 ? 3'b010 : 3'b001);
    endfunction

    // Executes one instruction and returns its cycle count
    function automatic int m_step();
        logic [15:0] ir, s5, s6, s9, s11, t;
        logic [2:0]  dr, br;
        ir   = m_rd(m_pc);
        m_pc = m_pc + 16'd1;
        dr   = ir[11:9];
        br   = ir[8:6];
        s5   = {{11{ir[4]}}, ir[4:0]};
        s6   = {{10{ir[5]}}, ir[5:0]};
        s9   = {{7{ir[8]}}, ir[8:0]};
        s11  = {{5{ir[10]}}, ir[10:0]};
        case (ir[15:12])
            4'h1: m_set(dr, m_reg[br] + (ir[5] ? s5 : m_reg[ir[2:0]]));
            4'h5: m_set(dr, m_reg[br] & (ir[5] ? s5 : m_reg[ir[2:0]]));
            4'h9: m_set(dr, ~m_reg[br]);
            4'hE: m_set(dr, m_pc + s9);
            4'h0: if ((dr & m_nzp) != 3'b000) m_pc = m_pc + s9;
            4'hC: m_pc = m_reg[br];
            4'h4: begin
                t = ir[11] ? m_pc + s11 : m_reg[br];
                m_reg[7] = m_pc;
                m_pc = t;
            end
            4'h2: begin m_set(dr, m_rd(m_pc + s9)); return 4; end
            4'h6: begin m_set(dr, m_rd(m_reg[br] + s6)); return 4; end
            4'hA: begin m_set(dr, m_rd(m_rd(m_pc + s9))); return 5; end
            4'h3: m_wr(m_pc + s9, m_reg[dr]);
            4'h7: m_wr(m_reg[br] + s6, m_reg[dr]);
            4'hB: begin m_wr(m_rd(m_pc + s9), m_reg[dr]); return 4; end
            4'hF: begin
                m_reg[7] = m_pc;
                if (ir[7:0] == 8'h25) begin
                    m_halt = 1'b1;
                end else begin
                    m_pc = m_rd({8'h00, ir[7:0]});
                    return 4;
                end
            end
            default: ;
        endcase
        return 3;
    endfunction

    initial begin
        int cyc;

        // ---- reset state and NOP stepping from zeroed RAM ----
        clear_img();
        load_hold();
        check("reset_pc", dut.pc_q, 16'h3000);
        check("reset_r0", dut.regs_q[0], 16'h0000);
        check("reset_nzp", {13'b0, dut.nzp_q}, 16'h0002);
        check("reset_kbsr", pad_kbsr, 16'h0000);
        check("reset_ddr", pad_ddr, 16'h0000);
        check("reset_dsr", pad_out_dsr, 16'h0000);
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick(3);
            check($sformatf("nop_pc%0d", k), dut.pc_q, 16'h3000 + 16'(k));
        end
        check("nop_ddr", pad_ddr, 16'h0000);
        check("nop_dsr", pad_out_dsr, 16'h0000);

        // ---- AND / ADD imm -1 / NOT and condition codes ----
        clear_img();
        img[0] = 16'h5020;  // AND R0,R0,#0
        img[1] = 16'h103F;  // ADD R0,R0,#-1
        img[2] = 16'h903F;  // NOT R0,R0
        start();
        tick(6);
        check("add_r0", dut.regs_q[0], 16'hFFFF);
        check("add_nzp", {13'b0, dut.nzp_q}, 16'h0004);
        tick(3);
        check("not_r0", dut.regs_q[0], 16'h0000);
        check("not_nzp", {13'b0, dut.nzp_q}, 16'h0002);

        // ---- keyboard poll/read and display write ----
        clear_img();
        img[0]    = 16'hA40F;  // LDI R2, ->KBSR
        img[1]    = 16'hA60F;  // LDI R3, ->KBDR
        img[2]    = 16'h2210;  // LD  R1, x0048
        img[3]    = 16'hB20E;  // STI R1, ->DDR
        img[8'h10] = 16'hFE00;
        img[8'h11] = 16'hFE02;
        img[8'h12] = 16'hFE06;
        img[8'h13] = 16'h0048;
        pad_in_dsr = 16'h8000;
        load_hold();
        rst = 1'b0;
        pad_kbdr = 16'h8041;
        tick(1);
        check("kb_ready_set", pad_kbsr, 16'h8000);
        check("dsr_ready_follow", pad_out_dsr, 16'h8000);
        tick(9);
        check("ldi_kbsr", dut.regs_q[2], 16'h8000);
        check("ldi_kbdr", dut.regs_q[3], 16'h0041);
        check("kb_ready_clr", pad_kbsr, 16'h0000);
        tick(7);
        check("pre_sti_dsr", pad_out_dsr, 16'h8000);
        check("pre_sti_ddr", pad_ddr, 16'h0000);
        tick(1);
        check("sti_ddr", pad_ddr, 16'h0048);
        check("sti_strobe", pad_out_dsr, 16'h0001);
        tick(1);
        check("post_strobe", pad_out_dsr, 16'h8000);
        check("post_ddr", pad_ddr, 16'h0048);
        pad_kbdr   = 16'h0000;
        pad_in_dsr = 16'h0000;

        // ---- JSR / RET ----
        clear_img();
        img[0] = 16'h4802;  // JSR +2
        img[3] = 16'hC1C0;  // RET
        start();
        tick(3);
        check("jsr_r7", dut.regs_q[7], 16'h3001);
        check("jsr_pc", dut.pc_q, 16'h3003);
        tick(3);
        check("ret_pc", dut.pc_q, 16'h3001);

        // ---- TRAP x25 halts; reset restarts ----
        clear_img();
        img[0] = 16'hF025;
        start();
        tick(3);
        check("halt_pc", dut.pc_q, 16'h3001);
        tick(10);
        check("halt_frozen", dut.pc_q, 16'h3001);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("halt_rst_pc", dut.pc_q, 16'h3000);
        tick(3);
        check("halt_rerun_pc", dut.pc_q, 16'h3001);

        // ---- reset in the middle of an instruction ----
        clear_img();
        start();
        tick(5);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mid_rst_pc", dut.pc_q, 16'h3000);
        tick(3);
        check("mid_rst_fetch", dut.pc_q, 16'h3001);

        // ---- random programs against the reference interpreter ----
        for (int p = 0; p < 12; p++) begin
            for (int i = 0; i < 256; i++) begin
                img[i]   = 16'($urandom);
                m_mem[i] = img[i];
            end
            for (int r = 0; r < 8; r++) m_reg[r] = 16'h0000;
            m_pc   = 16'h3000;
            m_nzp  = 3'b010;
            m_ddr  = 16'h0000;
            m_halt = 1'b0;
            cyc    = 0;
            for (int k = 0; k < 50 && !m_halt; k++) cyc += m_step();
            start();
            tick(cyc + (m_halt ? 6 : 0));
            for (int r = 0; r < 8; r++)
                check($sformatf("rand%0d_r%0d", p, r), dut.regs_q[r], m_reg[r]);
            check($sformatf("rand%0d_pc", p), dut.pc_q, m_pc);
            check($sformatf("rand%0d_nzp", p), {13'b0, dut.nzp_q}, {13'b0, m_nzp});
            check($sformatf("rand%0d_ddr", p), pad_ddr, m_ddr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
